// File: rtl/sipo_frame_rx.sv
// Serial-to-parallel frame receiver: shifts WIDTH framed bits into a word
// and hands it off through a valid/ready output register.
module sipo_frame_rx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             serial_en,
    input  logic             frame_start,
    input  logic             out_ready,
    input  logic             clear_err,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] pout_q, pout_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             ovr_q, ovr_d;
    logic             ferr_q, ferr_d;

    logic [WIDTH-1:0] base;
    logic [WIDTH-1:0] word;
    logic [CW-1:0]    cnt_base;
    logic [CW-1:0]    cnt_inc;
    logic             take;
    logic             restart;
    logic             done;
    logic             slot_free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            pout_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            pout_q  <= pout_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        pout_d  = pout_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        ferr_d  = 1'b0;

        restart  = serial_en && frame_start;
        take     = serial_en && (frame_start || (state_q == SHIFT));
        // A restart discards the partial word, so shift from an empty base
        base     = restart ? '0 : shift_q;
        cnt_base = restart ? '0 : cnt_q;
        cnt_inc  = cnt_base + CW'(1);
        if (MSB_FIRST) begin
            word = {base[WIDTH-2:0], serial_in};
        end else begin
            word = {serial_in, base[WIDTH-1:1]};
        end
        done      = take && (cnt_inc == CW'(WIDTH));
        slot_free = !valid_q || out_ready;

        if (take) begin
            ferr_d = restart && (state_q == SHIFT);
            if (done) begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end else begin
                state_d = SHIFT;
                shift_d = word;
                cnt_d   = cnt_inc;
            end
        end

        // Clear first so a same-edge drop still leaves overrun set
        if (clear_err) begin
            ovr_d = 1'b0;
        end

        if (done && slot_free) begin
            pout_d  = word;
            valid_d = 1'b1;
        end else if (done) begin
            ovr_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    assign parallel_out = pout_q;
    assign out_valid    = valid_q;
    assign busy         = (state_q == SHIFT);
    assign overrun      = ovr_q;
    assign frame_err    = ferr_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: MSB-first and LSB-first instances driven in
// parallel and compared each cycle against a frame-level model.
module tb_sipo_frame_rx;

    logic       clk = 1'b0;
    logic       rst_n, si, en, fs, rdy, clr;
    logic [7:0] a_pout, b_pout;
    logic       a_v, b_v, a_busy, b_busy, a_ovr, b_ovr, a_fe, b_fe;

    int n_chk  = 0;
    int n_fail = 0;
    int fe_cnt = 0;

    bit [7:0] m_pa, m_pb;
    bit       m_v, m_ov, m_fe, m_inf;
    bit       q[$];

    always #5 clk = ~clk;

    sipo_frame_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .serial_in(si), .serial_en(en),
        .frame_start(fs), .out_ready(rdy), .clear_err(clr),
        .parallel_out(a_pout), .out_valid(a_v), .busy(a_busy),
        .overrun(a_ovr), .frame_err(a_fe)
    );

    sipo_frame_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .serial_in(si), .serial_en(en),
        .frame_start(fs), .out_ready(rdy), .clear_err(clr),
        .parallel_out(b_pout), .out_valid(b_v), .busy(b_busy),
        .overrun(b_ovr), .frame_err(b_fe)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_edge();
        bit       done;
        bit [7:0] wa, wb;
        done = 1'b0;
        wa   = '0;
        wb   = '0;
        if (!rst_n) begin
            m_pa = '0; m_pb = '0; m_v = 0; m_ov = 0; m_fe = 0; m_inf = 0;
            q.delete();
        end else begin
            m_fe = 1'b0;
            if (en && fs) begin
                m_fe = m_inf;
                q.delete();
                q.push_back(si);
                m_inf = 1'b1;
            end else if (en && m_inf) begin
                q.push_back(si);
            end
            if (m_inf && q.size() == 8) begin
                done  = 1'b1;
                m_inf = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    wa[7-i] = q[i];
                    wb[i]   = q[i];
                end
                q.delete();
            end
            if (clr) m_ov = 1'b0;
            if (done && (!m_v || rdy)) begin
                m_pa = wa;
                m_pb = wb;
                m_v  = 1'b1;
            end else if (done) begin
                m_ov = 1'b1;
            end else if (m_v && rdy) begin
                m_v = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("a_pout", a_pout, m_pa);
        chk("b_pout", b_pout, m_pb);
        chk("a_valid", a_v, m_v);
        chk("b_valid", b_v, m_v);
        chk("a_busy", a_busy, m_inf);
        chk("b_busy", b_busy, m_inf);
        chk("a_ovr", a_ovr, m_ov);
        chk("b_ovr", b_ovr, m_ov);
        chk("a_ferr", a_fe, m_fe);
        chk("b_ferr", b_fe, m_fe);
        if (a_fe) fe_cnt++;
    endtask

    // Bits go out in w[7] .. w[8-n] order; rl raises out_ready on the last bit
    task automatic send(input logic [7:0] w, input int n, input int gap,
                        input bit rl);
        for (int i = 0; i < n; i++) begin
            for (int g = 0; g < gap; g++) begin
                en = 1'b0;
                fs = 1'b0;
                si = 1'($urandom);
                step();
            end
            si = w[7-i];
            en = 1'b1;
            fs = (i == 0);
            if (rl && i == n - 1) rdy = 1'b1;
            step();
        end
        en = 1'b0;
        fs = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; si = 0; en = 0; fs = 0; rdy = 0; clr = 0;
        step();
        step();
        chk("rst_pout", a_pout, 8'h00);
        chk("rst_valid", a_v, 1'b0);
        rst_n = 1'b1;
        step();

        rdy = 1'b1;
        send(8'hA5, 8, 0, 0);
        chk("t1_word", a_pout, 8'hA5);
        chk("t1_valid", a_v, 1'b1);
        step();
        chk("t1_valid_drop", a_v, 1'b0);

        send(8'hB4, 8, 0, 0);
        chk("t2_lsb_word", b_pout, 8'h2D);
        step();

        send(8'hA5, 8, 3, 0);
        chk("t3_word", a_pout, 8'hA5);
        chk("t3_valid", a_v, 1'b1);
        step();

        rdy = 1'b0;
        send(8'hA5, 8, 0, 0);
        send(8'h3C, 8, 0, 0);
        chk("t4_ovr", a_ovr, 1'b1);
        chk("t4_hold", a_pout, 8'hA5);
        chk("t4_valid", a_v, 1'b1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("t4_clr", a_ovr, 1'b0);
        send(8'h3C, 8, 0, 1);
        chk("t4_load", a_pout, 8'h3C);
        chk("t4_no_ovr", a_ovr, 1'b0);
        step();

        fe_cnt = 0;
        send(8'hFF, 3, 0, 0);
        send(8'h3C, 8, 0, 0);
        step();
        chk("t5_fe_cnt", fe_cnt, 1);
        chk("t5_word", a_pout, 8'h3C);
        chk("t5_ovr", a_ovr, 1'b0);

        send(8'h5A, 4, 0, 0);
        rst_n = 1'b0;
        step();
        chk("t6_busy", a_busy, 1'b0);
        chk("t6_pout", a_pout, 8'h00);
        chk("t6_valid", a_v, 1'b0);
        rst_n = 1'b1;
        send(8'hA5, 8, 0, 0);
        chk("t6_word", a_pout, 8'hA5);

        for (int c = 0; c < 2000; c++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            si    = 1'($urandom);
            en    = ($urandom_range(0, 3) != 0);
            fs    = ($urandom_range(0, 11) == 0);
            rdy   = ($urandom_range(0, 2) != 0);
            clr   = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
